ifetch_queue: RTL and testbench

//  Instruction fetch stage that sits directly upstream of the decoder. Holds the fetch PC and

---
 rtl/ifetch_queue.sv | 177 +++++++++++++++++
 tb/tb_ifetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: holds the fetch PC, issues word reads over req/ack, queues {pc, word}.
// Latency: an ack into an empty queue shows ir_valid one cycle later; ir/ir_pc are registered.
// Backpressure: ir_ready low fills the queue, after which no new request is issued until a pop.
//
// Ports: clk/rst (sync, active-high); mem_req/mem_addr/mem_ack/mem_rdata (memory read channel);
//        ir_valid/ir/ir_pc/ir_ready (decoder handshake); redir_valid/redir_pc (jump restart);
//        halt (stop fetching, level-sampled and sticky); fault (sticky misaligned-redirect flag).
module ifetch_queue #(
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        halt,
    output logic        fault
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = QDEPTH;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FULL, S_DRAIN, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   drain_addr_q, drain_addr_d;
    logic          halt_pend_q, halt_pend_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   q_pc_q [QDEPTH];
    logic [31:0]   q_pc_d [QDEPTH];
    logic [31:0]   q_dat_q [QDEPTH];
    logic [31:0]   q_dat_d [QDEPTH];
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   ir_pc_q, ir_pc_d;

    logic outstanding;
    logic halt_now;
    logic pop;
    logic push;

    assign outstanding = (state_q == S_REQ) || (state_q == S_DRAIN);
    // halt may drop before an outstanding request completes; the pending flag remembers it
    assign halt_now    = halt | halt_pend_q;
    assign pop         = (count_q != '0) & ir_ready;
    // an ack coinciding with a redirect belongs to the old stream and is dropped
    assign push        = (state_q == S_REQ) & mem_ack & ~redir_valid;

    assign mem_req  = outstanding;
    // while draining, the address of the abandoned request stays on the bus
    assign mem_addr = (state_q == S_DRAIN) ? drain_addr_q : {pc_q[31:2], 2'b00};
    assign ir_valid = (count_q != '0);
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign fault    = fault_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        halt_pend_d  = halt_pend_q | halt;
        fault_d      = fault_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        q_pc_d       = q_pc_q;
        q_dat_d      = q_dat_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_d - CNT_ONE;
        end
        if (push) begin
            q_pc_d[wr_ptr_q]  = pc_q;
            q_dat_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
            count_d           = count_d + CNT_ONE;
        end
        // Refresh the registered head. When the new head is the entry being written this
        // cycle (empty queue, or pop of the last entry), bypass the storage array.
        if (push || pop) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                ir_d    = mem_rdata;
                ir_pc_d = pc_q;
            end else begin
                ir_d    = q_dat_q[rd_ptr_d];
                ir_pc_d = q_pc_q[rd_ptr_d];
            end
        end

        case (state_q)
            S_IDLE:  state_d = halt_now ? S_HALT : S_REQ;
            S_REQ: begin
                if (mem_ack) begin
                    pc_d = pc_q + 32'd4;
                    if (halt_now)                state_d = S_HALT;
                    else if (count_d == CNT_FULL) state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (halt_now)  state_d = S_HALT;
                else if (pop)  state_d = S_REQ;
            end
            S_DRAIN: begin
                if (mem_ack) state_d = halt_now ? S_HALT : S_REQ;
            end
            default: state_d = S_HALT;
        endcase

        if (redir_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = redir_pc;
            if (redir_pc[1:0] != 2'b00) begin
                // misaligned target: abandon any outstanding request and stop for good
                fault_d = 1'b1;
                state_d = S_HALT;
            end else if (state_q != S_HALT) begin
                if (outstanding && !mem_ack) begin
                    drain_addr_d = mem_addr;
                    state_d      = S_DRAIN;
                end else begin
                    state_d = halt_now ? S_HALT : S_REQ;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            halt_pend_q  <= 1'b0;
            fault_q      <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ir_q         <= '0;
            ir_pc_q      <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc_q[i]  <= '0;
                q_dat_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            halt_pend_q  <= halt_pend_d;
            fault_q      <= fault_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            q_pc_q       <= q_pc_d;
            q_dat_q      <= q_dat_d;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (QDEPTH=2, RESET_PC=0).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Memory contents are modelled as word(a) = a ^ 32'hDEADBEEF.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        halt;
    logic        fault;

    int n_run  = 0;
    int n_fail = 0;

    ifetch_queue #(.QDEPTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .halt(halt), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
        redir_valid = 1'b0; redir_pc = '0; halt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
        redir_valid = 1'b0; redir_pc = '0; halt = 1'b0;
        tick();
        tick();
        n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %h want 0", mem_req); end
        n_run++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_run++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %h want 0", ir_valid); end
        n_run++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", ir); end
        n_run++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ir_pc: got %h want 0", ir_pc); end
        n_run++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %h want 0", fault); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [4];
        logic [31:0] wds [4];
        int npop = 0;
        int misalign = 0;
        apply_reset();
        ir_ready = 1'b1;
        for (int c = 0; c < 40 && npop < 4; c++) begin
            tick();
            if (mem_addr[1:0] != 2'b00) misalign++;
            if (ir_valid) begin pcs[npop] = ir_pc; wds[npop] = ir; npop++; end
            if (mem_req && !mem_ack) begin mem_ack = 1'b1; mem_rdata = memw(mem_addr); end
            else mem_ack = 1'b0;
        end
        mem_ack = 1'b0;
        n_run++; if (npop != 4) begin n_fail++; $display("FAIL stream_pop_count: got %0d want 4", npop); end
        for (int i = 0; i < npop; i++) begin
            n_run++; if (pcs[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc%0d: got %h want %h", i, pcs[i], 32'(4 * i)); end
            n_run++; if (wds[i] !== memw(32'(4 * i))) begin n_fail++; $display("FAIL stream_ir%0d: got %h want %h", i, wds[i], memw(32'(4 * i))); end
        end
        n_run++; if (misalign != 0) begin n_fail++; $display("FAIL stream_align: got %0d misaligned want 0", misalign); end
    endtask

    task automatic test_full();
        int nack = 0;
        apply_reset();
        ir_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (mem_req && !mem_ack) begin mem_ack = 1'b1; mem_rdata = memw(mem_addr); nack++; end
            else mem_ack = 1'b0;
        end
        mem_ack = 1'b0;
        n_run++; if (nack != 2) begin n_fail++; $display("FAIL full_acks: got %0d want 2", nack); end
        n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %h want 0", mem_req); end
        n_run++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0) begin n_fail++; $display("FAIL full_head: got v=%h pc=%h want v=1 pc=0", ir_valid, ir_pc); end
        ir_ready = 1'b1;
        tick();
        n_run++; if (ir_valid !== 1'b1 || ir_pc !== 32'h4) begin n_fail++; $display("FAIL full_pop1: got v=%h pc=%h want v=1 pc=4", ir_valid, ir_pc); end
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_fail++; $display("FAIL full_rereq: got req=%h addr=%h want req=1 addr=8", mem_req, mem_addr); end
        tick();
        n_run++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop2: got v=%h want 0", ir_valid); end
    endtask

    // continues from test_full: request for 8 outstanding, queue empty, ir_ready=1
    task automatic test_drain();
        redir_valid = 1'b1; redir_pc = 32'h40;
        tick();
        redir_valid = 1'b0;
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_fail++; $display("FAIL drain_hold1: got req=%h addr=%h want req=1 addr=8", mem_req, mem_addr); end
        tick();
        tick();
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_fail++; $display("FAIL drain_hold3: got req=%h addr=%h want req=1 addr=8", mem_req, mem_addr); end
        n_run++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got v=%h want 0", ir_valid); end
        mem_ack = 1'b1; mem_rdata = memw(32'h8);
        tick();
        mem_ack = 1'b0;
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL drain_newaddr: got req=%h addr=%h want req=1 addr=40", mem_req, mem_addr); end
        n_run++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL drain_dropped: got v=%h want 0", ir_valid); end
        mem_ack = 1'b1; mem_rdata = memw(32'h40);
        tick();
        mem_ack = 1'b0;
        n_run++; if (ir_valid !== 1'b1 || ir_pc !== 32'h40 || ir !== memw(32'h40)) begin n_fail++; $display("FAIL drain_first: got v=%h pc=%h ir=%h want v=1 pc=40 ir=%h", ir_valid, ir_pc, ir, memw(32'h40)); end
    endtask

    // continues: request for 44 outstanding, 40 at the head being popped
    task automatic test_redir_ack();
        mem_ack = 1'b1; mem_rdata = memw(32'h44); redir_valid = 1'b1; redir_pc = 32'h100;
        tick();
        mem_ack = 1'b0; redir_valid = 1'b0;
        n_run++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL redack_flush: got v=%h want 0", ir_valid); end
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL redack_addr: got req=%h addr=%h want req=1 addr=100", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = memw(32'h100);
        tick();
        mem_ack = 1'b0;
        n_run++; if (ir_valid !== 1'b1 || ir_pc !== 32'h100 || ir !== memw(32'h100)) begin n_fail++; $display("FAIL redack_head: got v=%h pc=%h ir=%h want v=1 pc=100 ir=%h", ir_valid, ir_pc, ir, memw(32'h100)); end
    endtask

    task automatic test_fault();
        int nreq = 0;
        redir_valid = 1'b1; redir_pc = 32'h42;
        tick();
        redir_valid = 1'b0;
        n_run++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_set: got %h want 1", fault); end
        n_run++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL fault_stop: got req=%h v=%h want 0 0", mem_req, ir_valid); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_req) nreq++;
        end
        n_run++; if (nreq != 0) begin n_fail++; $display("FAIL fault_noreq: got %0d req cycles want 0", nreq); end
        n_run++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %h want 1", fault); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_run++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %h want 0", fault); end
    endtask

    task automatic test_halt_wrap();
        int nreq = 0;
        apply_reset();
        tick();
        redir_valid = 1'b1; redir_pc = 32'hFFFFFFFC;
        tick();
        redir_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = memw(32'h0);
        tick();
        mem_ack = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL halt_pending: got req=%h addr=%h want req=1 addr=fffffffc", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = memw(32'hFFFFFFFC);
        tick();
        mem_ack = 1'b0;
        n_run++; if (ir_valid !== 1'b1 || ir_pc !== 32'hFFFFFFFC || ir !== memw(32'hFFFFFFFC)) begin n_fail++; $display("FAIL halt_deliver: got v=%h pc=%h ir=%h want v=1 pc=fffffffc ir=%h", ir_valid, ir_pc, ir, memw(32'hFFFFFFFC)); end
        n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req: got %h want 0", mem_req); end
        ir_ready = 1'b1;
        tick();
        n_run++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drain: got v=%h want 0", ir_valid); end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_req) nreq++;
        end
        n_run++; if (nreq != 0) begin n_fail++; $display("FAIL halt_noreq: got %0d req cycles want 0", nreq); end
        // same sequence without halt: the address after fffffffc wraps to 0
        apply_reset();
        tick();
        redir_valid = 1'b1; redir_pc = 32'hFFFFFFFC;
        tick();
        redir_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = memw(32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = memw(32'hFFFFFFFC);
        tick();
        mem_ack = 1'b0;
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got req=%h addr=%h want req=1 addr=0", mem_req, mem_addr); end
        n_run++; if (ir_valid !== 1'b1 || ir_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_head: got v=%h pc=%h want v=1 pc=fffffffc", ir_valid, ir_pc); end
    endtask

    // continues: request for 0 outstanding, one entry queued, ir_ready=0
    task automatic test_reset_mid();
        mem_ack = 1'b1; mem_rdata = memw(32'h0);
        tick();
        mem_ack = 1'b0;
        n_run++; if (mem_req !== 1'b0 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_full: got req=%h v=%h want req=0 v=1", mem_req, ir_valid); end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got req=%h addr=%h v=%h want 1 4 1", mem_req, mem_addr, ir_valid); end
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = memw(32'h4);
        tick();
        rst = 1'b0; mem_ack = 1'b0;
        n_run++; if (ir_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_reset: got v=%h req=%h addr=%h want 0 0 0", ir_valid, mem_req, mem_addr); end
        tick();
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_restart: got req=%h addr=%h want req=1 addr=0", mem_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_drain();
        test_redir_ack();
        test_fault();
        test_halt_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
